// File: rtl/fifo_ctrl.sv
// FIFO controller for an external async-read RAM: zero added read latency, push visible after its edge.
// Backpressure: o_push_ready = !o_full (no same-cycle pop bypass); optional o_level via FIFO_CTRL_LEVEL_EN.
module fifo_ctrl #(
  parameter int DATA_WIDTH   = 8,
  parameter int RAM_DEPTH    = 8,
  parameter int AFULL_THRESH = RAM_DEPTH - 2,
  localparam int AW          = $clog2(RAM_DEPTH)
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic                  i_flush,
  input  logic                  i_push_valid,
  output logic                  o_push_ready,
  input  logic [DATA_WIDTH-1:0] i_push_data,
  output logic                  o_pop_valid,
  input  logic                  i_pop_ready,
  output logic [DATA_WIDTH-1:0] o_pop_data,
  output logic                  o_ram_wr_en,
  output logic [AW-1:0]         o_ram_wr_addr,
  output logic [DATA_WIDTH-1:0] o_ram_wr_data,
  output logic                  o_ram_rd_en,
  output logic [AW-1:0]         o_ram_rd_addr,
  input  logic [DATA_WIDTH-1:0] i_ram_rd_data,
  output logic                  o_full,
  output logic                  o_empty,
  output logic                  o_afull
`ifdef FIFO_CTRL_LEVEL_EN
  ,
  output logic [AW:0]           o_level
`endif
);

  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic [AW:0] occ;
  logic        push_acc;
  logic        pop_acc;

  // Wrap bit distinguishes full from empty when the address bits coincide.
  assign o_empty = (wr_ptr == rd_ptr);
  assign o_full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign occ     = wr_ptr - rd_ptr;
  assign o_afull = (32'(occ) >= AFULL_THRESH);

  assign o_push_ready = !o_full;
  assign o_pop_valid  = !o_empty;

  // n_rst gates the write strobe so the RAM sees no write while reset is held.
  assign push_acc = i_push_valid && !o_full && !i_flush && n_rst;
  assign pop_acc  = o_pop_valid && i_pop_ready && !i_flush;

  assign o_ram_wr_en   = push_acc;
  assign o_ram_wr_addr = wr_ptr[AW-1:0];
  assign o_ram_wr_data = i_push_data;
  assign o_ram_rd_en   = !o_empty;
  assign o_ram_rd_addr = rd_ptr[AW-1:0];
  assign o_pop_data    = i_ram_rd_data;

`ifdef FIFO_CTRL_LEVEL_EN
  assign o_level = occ;
`endif

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (i_flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_acc) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop_acc)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

endmodule

// File: tb/tb_fifo_ctrl.sv
// Randomized and directed bench for fifo_ctrl against a queue-based reference model.
module tb_fifo_ctrl;
  localparam int DW    = 8;
  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic          clk;
  logic          n_rst;
  logic          i_flush;
  logic          i_push_valid;
  logic          o_push_ready;
  logic [DW-1:0] i_push_data;
  logic          o_pop_valid;
  logic          i_pop_ready;
  logic [DW-1:0] o_pop_data;
  logic          o_ram_wr_en;
  logic [AW-1:0] o_ram_wr_addr;
  logic [DW-1:0] o_ram_wr_data;
  logic          o_ram_rd_en;
  logic [AW-1:0] o_ram_rd_addr;
  logic [DW-1:0] i_ram_rd_data;
  logic          o_full;
  logic          o_empty;
  logic          o_afull;
`ifdef FIFO_CTRL_LEVEL_EN
  logic [AW:0]   o_level;
`endif

  fifo_ctrl #(.DATA_WIDTH(DW), .RAM_DEPTH(DEPTH)) dut (
    .clk(clk), .n_rst(n_rst), .i_flush(i_flush),
    .i_push_valid(i_push_valid), .o_push_ready(o_push_ready), .i_push_data(i_push_data),
    .o_pop_valid(o_pop_valid), .i_pop_ready(i_pop_ready), .o_pop_data(o_pop_data),
    .o_ram_wr_en(o_ram_wr_en), .o_ram_wr_addr(o_ram_wr_addr), .o_ram_wr_data(o_ram_wr_data),
    .o_ram_rd_en(o_ram_rd_en), .o_ram_rd_addr(o_ram_rd_addr), .i_ram_rd_data(i_ram_rd_data),
    .o_full(o_full), .o_empty(o_empty), .o_afull(o_afull)
`ifdef FIFO_CTRL_LEVEL_EN
    , .o_level(o_level)
`endif
  );

  // Environment RAM: synchronous write, asynchronous read.
  logic [DW-1:0] ram [DEPTH];
  always @(posedge clk) if (o_ram_wr_en) ram[o_ram_wr_addr] <= o_ram_wr_data;
  assign i_ram_rd_data = ram[o_ram_rd_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DW-1:0] q[$];
  int wr_cnt = 0;
  int rd_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    q.delete();
    wr_cnt = 0;
    rd_cnt = 0;
  endtask

  task automatic check_outputs();
    int occ;
    bit acc;
    occ = q.size();
    acc = i_push_valid && !i_flush && (occ < DEPTH);
    chk("empty",      32'(o_empty),      32'(occ == 0));
    chk("full",       32'(o_full),       32'(occ == DEPTH));
    chk("afull",      32'(o_afull),      32'(occ >= DEPTH - 2));
    chk("push_ready", 32'(o_push_ready), 32'(occ != DEPTH));
    chk("pop_valid",  32'(o_pop_valid),  32'(occ != 0));
    chk("rd_en",      32'(o_ram_rd_en),  32'(occ != 0));
    chk("wr_en",      32'(o_ram_wr_en),  32'(acc));
    if (acc) begin
      chk("wr_addr", 32'(o_ram_wr_addr), wr_cnt % DEPTH);
      chk("wr_data", 32'(o_ram_wr_data), 32'(i_push_data));
    end
    if (occ > 0) begin
      chk("rd_addr",  32'(o_ram_rd_addr), rd_cnt % DEPTH);
      chk("pop_data", 32'(o_pop_data),    32'(q[0]));
    end
`ifdef FIFO_CTRL_LEVEL_EN
    chk("level", 32'(o_level), occ);
`endif
  endtask

  task automatic commit();
    int occ;
    @(posedge clk);
    occ = q.size();
    if (i_flush) begin
      model_clear();
    end else begin
      if (i_pop_ready && occ > 0) begin
        void'(q.pop_front());
        rd_cnt++;
      end
      if (i_push_valid && occ < DEPTH) begin
        q.push_back(i_push_data);
        wr_cnt++;
      end
    end
    #1;
  endtask

  task automatic step(input bit pv, input logic [DW-1:0] pd, input bit pr, input bit fl);
    i_push_valid = pv;
    i_push_data  = pd;
    i_pop_ready  = pr;
    i_flush      = fl;
    #3;
    check_outputs();
    commit();
  endtask

  task automatic check_reset_values();
    chk("rst_empty",      32'(o_empty),      32'd1);
    chk("rst_full",       32'(o_full),       32'd0);
    chk("rst_afull",      32'(o_afull),      32'd0);
    chk("rst_push_ready", 32'(o_push_ready), 32'd1);
    chk("rst_pop_valid",  32'(o_pop_valid),  32'd0);
    chk("rst_wr_en",      32'(o_ram_wr_en),  32'd0);
    chk("rst_rd_en",      32'(o_ram_rd_en),  32'd0);
  endtask

  initial begin
    n_rst = 1'b0;
    i_flush = 1'b0;
    i_push_valid = 1'b1;
    i_push_data = 8'hAA;
    i_pop_ready = 1'b0;
    #2;
    check_reset_values();
    @(posedge clk);
    #1;
    n_rst = 1'b1;
    i_push_valid = 1'b0;
    model_clear();

    // Fill: 8 words, then a 9th push that must not be written.
    for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
    chk("fill_full",  32'(o_full),       32'd1);
    chk("fill_ready", 32'(o_push_ready), 32'd0);
    step(1'b1, 8'h18, 1'b0, 1'b0);

    // Drain in order.
    for (int i = 0; i < DEPTH; i++) begin
      i_push_valid = 1'b0;
      i_pop_ready  = 1'b1;
      #3;
      chk("drain_order", 32'(o_pop_data), 32'(8'h10 + i));
      check_outputs();
      commit();
    end
    i_pop_ready = 1'b0;
    #3;
    chk("drain_empty", 32'(o_empty),     32'd1);
    chk("drain_rd_en", 32'(o_ram_rd_en), 32'd0);

    // Wrap: steady occupancy 3 with simultaneous push/pop.
    for (int i = 0; i < 3; i++) step(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
    for (int i = 3; i < 23; i++) step(1'b1, 8'(8'h40 + i), 1'b1, 1'b0);
    chk("wrap_occ", 32'(q.size()), 32'd3);

    // Full with simultaneous push and pop: only the pop happens.
    while (q.size() < DEPTH) step(1'b1, 8'($urandom), 1'b0, 1'b0);
    step(1'b1, 8'hEE, 1'b1, 1'b0);
    #3;
    chk("full_pp_full", 32'(o_full), 32'd0);
    commit();

    // Flush at occupancy 5 with a push pending.
    while (q.size() > 5) step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b1, 8'h77, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b0);

    // Reset mid-burst for half a clock period while a push is presented.
    for (int i = 0; i < 4; i++) step(1'b1, 8'(8'h60 + i), 1'b0, 1'b0);
    i_push_valid = 1'b1;
    i_push_data  = 8'h99;
    i_pop_ready  = 1'b0;
    i_flush      = 1'b0;
    #1;
    n_rst = 1'b0;
    model_clear();
    #1;
    check_reset_values();
    #4;
    n_rst = 1'b1;
    #1;
    check_outputs();
    chk("rst_next_addr", 32'(o_ram_wr_addr), 32'd0);
    commit();

    // Randomized traffic with phases of differing push/pop bias.
    for (int i = 0; i < 600; i++) begin
      int bias;
      bias = (i / 60) % 3;
      step(($urandom_range(0, 9) < (bias == 0 ? 8 : (bias == 1 ? 2 : 5))),
           8'($urandom),
           ($urandom_range(0, 9) < (bias == 0 ? 2 : (bias == 1 ? 8 : 5))),
           ($urandom_range(0, 63) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/fifo_ctrl.md
FIFO_CTRL -- requirements
Module: fifo_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, width of the stored word.
REQ-002 SHALL have parameter RAM_DEPTH, default 8, number of entries; power of two and at least 2.
REQ-003 SHALL have parameter AFULL_THRESH, default RAM_DEPTH-2, occupancy at or above which the almost-full flag asserts.
REQ-004 SHALL define AW as clog2(RAM_DEPTH).
REQ-005 Ports (clock and reset first):
- clk  in  1  single clock.
- n_rst  in  1  reset, asynchronous and active-low.
- i_flush  in  1  synchronous clear of all contents.
- i_push_valid  in  1  producer has a word.
- o_push_ready  out  1  controller accepts a word.
- i_push_data  in  DATA_WIDTH  producer word.
- o_pop_valid  out  1  head word available.
- i_pop_ready  in  1  consumer takes the word.
- o_pop_data  out  DATA_WIDTH  head word.
- o_ram_wr_en  out  1  RAM write enable.
- o_ram_wr_addr  out  AW  RAM write address.
- o_ram_wr_data  out  DATA_WIDTH  RAM write data.
- o_ram_rd_en  out  1  RAM read enable.
- o_ram_rd_addr  out  AW  RAM read address.
- i_ram_rd_data  in  DATA_WIDTH  RAM asynchronous read data.
- o_full  out  1  occupancy equals RAM_DEPTH.
- o_empty  out  1  occupancy is zero.
- o_afull  out  1  occupancy is at least AFULL_THRESH.

Function
REQ-006 SHALL hold write and read pointers of AW+1 bits each: AW address bits plus one wrap bit.
REQ-007 SHALL assert o_empty when both pointers are fully equal, and o_full when address bits are equal and wrap bits differ.
REQ-008 SHALL drive o_push_ready = !o_full, with no bypass when a pop occurs in the same cycle.
REQ-009 SHALL accept a push when i_push_valid && o_push_ready at a clk rising edge.
REQ-010 SHALL drive o_ram_wr_en = push accepted, combinationally.
REQ-011 SHALL drive o_ram_wr_addr = write-pointer address bits and o_ram_wr_data = i_push_data.
REQ-012 SHALL drive o_pop_valid = !o_empty.
REQ-013 SHALL drive o_ram_rd_en = !o_empty and o_ram_rd_addr = read-pointer address bits.
REQ-014 SHALL pass o_pop_data = i_ram_rd_data, giving zero added read latency.
REQ-015 SHALL complete a pop when o_pop_valid && i_pop_ready at a clk rising edge.
REQ-016 SHALL increment each pointer by 1 per accepted transfer, with the address wrapping from RAM_DEPTH-1 to 0 and the wrap bit toggling.
REQ-017 SHALL handle a simultaneous push and pop by advancing both pointers, leaving occupancy unchanged.
REQ-018 SHALL make a word pushed at edge N visible on o_pop_valid/o_pop_data after edge N; there is no empty-FIFO fall-through in the same cycle.
REQ-019 SHALL, on i_flush high at an edge, zero both pointers with priority over any push or pop in that cycle.
REQ-020 SHALL force o_ram_wr_en low while i_flush is high.
REQ-021 SHALL derive o_full, o_empty and o_afull combinationally from the registered pointers, so they update in the cycle after the causing edge.
REQ-022 SHALL ignore pushes while full and pops while empty, with no state change and no RAM write.

Reset
REQ-023 SHALL, while n_rst is low, asynchronously clear both pointers, irrespective of clk.
REQ-024 SHALL, while n_rst is low, drive o_empty=1, o_full=0, o_afull=0 (0 only while AFULL_THRESH>0), o_push_ready=1, o_pop_valid=0, o_ram_wr_en=0 and o_ram_rd_en=0.
REQ-025 SHALL discard all contents when reset is applied mid-operation; the first push after release goes to RAM address 0.

Configuration
REQ-026 SHALL, with macro FIFO_CTRL_LEVEL_EN defined, add port o_level  out  AW+1, giving occupancy = write pointer minus read pointer modulo 2^(AW+1).
REQ-027 SHALL make o_level reset to 0 and update in the cycle after each transfer.
REQ-028 SHALL, without FIFO_CTRL_LEVEL_EN, omit the o_level port and its subtractor, leaving all other behaviour identical.

Verification
REQ-029 SHALL cover fill: DEPTH=8, push 8 words 0x10..0x17 with pop_ready=0 -> o_full=1 and o_push_ready=0 after the 8th edge; o_afull=1 after the 6th edge; a 9th push is not written.
REQ-030 SHALL cover drain: from full, pop 8 with push_valid=0 -> o_pop_data reads 0x10..0x17 in order; o_empty=1 after the 8th edge; o_ram_rd_en=0.
REQ-031 SHALL cover wrap: 20 push/pop pairs of an incrementing pattern at occupancy 3 -> output order preserved; addresses wrap 7->0; occupancy (o_level when enabled) stays 3.
REQ-032 SHALL cover full with simultaneous push and pop: push_valid=1, pop_ready=1 while full -> one pop only; o_full=0 the next cycle.
REQ-033 SHALL cover flush: i_flush=1 with push_valid=1 and occupancy 5 -> o_empty=1 next cycle; o_ram_wr_en=0 in the flush cycle.
REQ-034 SHALL cover reset mid-burst: n_rst low for half a clk period during a push -> flags and outputs at reset values immediately; the next push writes address 0.
